element_wise_in_data_cvt_cell: RTL
==================================

# element_wise_in_data_cvt_cell

Converts one signed fixed-point operand per cycle into IEEE-754 fp32 for the element-wise processing datapath. It sits at the input of the element-wise engine and is the inverse of the output conversion cell: that cell turns fp32 results into fixed-point, and this cell turns fixed-point stream data into fp32 before the arithmetic stages. It is a 3-stage valid-only pipeline with clock-enable and side-band ("info along") passthrough.

## Interface
- INFO_ALONG_WIDTH, 2, width of side-band data carried alongside each operand
- S32_IN_DATA_SUPPORTED, 1'b1, when 0 the S32 format decodes as NONE (pass-through)
- SIM_DELAY, 1, register-assignment delay used in simulation only
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  synchronous, active-high reset
- aclken  in  1  clock enable; when 0 every register holds its value
- bypass  in  1  1: copy the operand to the output unchanged, with the same latency
- in_data_fmt  in  2  2'b00 = S16 (low 16 bits, sign-extended), 2'b01 = S32, 2'b10 = NONE (pass-through), 2'b11 = reserved, treated as NONE
- fixed_point_quat_accrc  in  6  Q = number of fractional bits, range 0..63
- cvt_cell_i_op_x  in  32  fixed-point operand
- cvt_cell_i_info_along  in  INFO_ALONG_WIDTH  side-band data
- cvt_cell_i_vld  in  1  input valid
- cvt_cell_o_res  out  32  fp32 result, or the raw operand in pass-through
- cvt_cell_o_info_along  out  INFO_ALONG_WIDTH  side-band data, delayed to match the result
- cvt_cell_o_vld  out  1  output valid

## Operation
- Value converted: x / 2^Q, where x is a signed integer.
- Stage 1: sign-extend x according to the format. Register sign = x[31], mag = |x| as 32-bit unsigned (so -2^31 gives 0x80000000), and zero flag = (x == 0).
- Stage 2: count leading zeros of mag. lz is in 0..31. Register lz, mag, sign and the zero flag.
- Stage 3: normalise n = mag << lz, so bit 31 is the leading one.
  - Exponent E = 31 - lz - Q + 127. E stays within 64..158, so no denormal or overflow handling is needed.
  - Mantissa M = n[30:8]. Guard bit g = n[7]; sticky s = |n[6:0].
  - Rounding is set by the macro (see Configuration). A mantissa carry-out sets M = 0 and E = E + 1.
  - Result = {sign, E[7:0], M}.
- Zero input: result is 0x00000000. Negative zero is never produced.
- Pass-through (bypass = 1 or NONE format): op_x is delayed three stages unchanged.
- Info-along and valid travel in lockstep with the data through all three stages.
- No back-pressure. A valid input is always accepted when aclken = 1.
- bypass, in_data_fmt and fixed_point_quat_accrc are quasi-static. They may change only when no valid is in flight; otherwise the results in flight are undefined.

## Timing
- Latency: exactly 3 cycles with aclken = 1 (input valid at edge N gives output valid after edge N+3). Throughput: 1 operand per cycle.
- When aclken = 0 the whole pipeline freezes, valid bits included. The output holds its value and cvt_cell_o_vld keeps its current level.
- Reset: all stage valid bits are cleared. cvt_cell_o_vld = 0, cvt_cell_o_res = 0 and cvt_cell_o_info_along = 0 the cycle after areset is sampled high.
- areset takes priority over aclken.
- Reset in the middle of a stream drops all in-flight operands; no partial outputs are produced afterwards.
- Back-to-back valids with mixed signs or zeros must produce one output per cycle with no bubbles.

## Configuration
- Macro ELM_IN_CVT_ROUND_EN.
- Defined: round to nearest, ties to even. M is incremented when g & (s | M[0]).
- Undefined: truncate. g and s are ignored, and the rounding adder and carry logic are removed.
- S16 inputs never produce rounding, because mag ≤ 2^15 leaves g and s at 0.

## Test plan
- S32, Q = 16, back-to-back inputs 0x00010000, 0xFFFE0000, 0x00000000, 0x0001999A -> outputs 0x3F800000, 0xC0000000, 0x00000000, 0x3FCCCD00 on four consecutive cycles, 3 cycles after the inputs.
- S32, Q = 16, x = 0x80000000 -> 0xC7000000 (-32768.0).
- S32, Q = 0, x = 0x7FFFFFFF -> 0x4F000000 with ELM_IN_CVT_ROUND_EN defined; 0x4EFFFFFF without it.
- S16, Q = 8, op_x = 0x12348000 -> 0xC3000000 (-128.0); the upper bits are ignored.
- bypass = 1 (and separately NONE format), op_x = 0xDEADBEEF, info_along = 2'b01 -> outputs 0xDEADBEEF and 2'b01 after 3 cycles.
- Hold aclken low for 2 cycles mid-stream, then pulse areset with 2 operands in flight -> output holds during the freeze; after reset cvt_cell_o_vld = 0 and the in-flight operands are never emitted.

Source files
------------

// File: rtl/element_wise_in_data_cvt_cell.sv
// Signed fixed-point (x / 2^Q) to fp32 converter, 3-stage valid-only pipeline with clock enable.
// Optional macro ELM_IN_CVT_ROUND_EN: round-to-nearest-even instead of truncation.
module element_wise_in_data_cvt_cell #(
  parameter int INFO_ALONG_WIDTH      = 2,
  parameter bit S32_IN_DATA_SUPPORTED = 1'b1,
  parameter int SIM_DELAY             = 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        aclken,
  input  logic                        bypass,
  input  logic [1:0]                  in_data_fmt,
  input  logic [5:0]                  fixed_point_quat_accrc,
  input  logic [31:0]                 cvt_cell_i_op_x,
  input  logic [INFO_ALONG_WIDTH-1:0] cvt_cell_i_info_along,
  input  logic                        cvt_cell_i_vld,
  output logic [31:0]                 cvt_cell_o_res,
  output logic [INFO_ALONG_WIDTH-1:0] cvt_cell_o_info_along,
  output logic                        cvt_cell_o_vld
);

  localparam logic [1:0] FMT_S16 = 2'b00;
  localparam logic [1:0] FMT_S32 = 2'b01;

  // Stage 1 registers
  logic                        s1_vld_q;
  logic [INFO_ALONG_WIDTH-1:0] s1_info_q;
  logic                        s1_pass_q, s1_pass_d;
  logic                        s1_sign_q, s1_sign_d;
  logic                        s1_zero_q, s1_zero_d;
  logic [31:0]                 s1_mag_q, s1_mag_d;

  // Stage 2 registers
  logic                        s2_vld_q;
  logic [INFO_ALONG_WIDTH-1:0] s2_info_q;
  logic                        s2_pass_q;
  logic                        s2_sign_q;
  logic                        s2_zero_q;
  logic [31:0]                 s2_mag_q;
  logic [4:0]                  s2_lz_q, s2_lz_d;

  // Stage 3 (output) registers
  logic                        s3_vld_q;
  logic [INFO_ALONG_WIDTH-1:0] s3_info_q;
  logic [31:0]                 s3_res_q, s3_res_d;

  logic        fmt_s16;
  logic        fmt_s32;
  logic [31:0] x_ext;

  // In pass-through the raw operand rides in the magnitude register.
  always_comb begin
    fmt_s16   = (in_data_fmt == FMT_S16);
    fmt_s32   = (in_data_fmt == FMT_S32) && S32_IN_DATA_SUPPORTED;
    x_ext     = fmt_s16 ? {{16{cvt_cell_i_op_x[15]}}, cvt_cell_i_op_x[15:0]} : cvt_cell_i_op_x;
    s1_pass_d = bypass | ~(fmt_s16 | fmt_s32);
    s1_sign_d = ~s1_pass_d & x_ext[31];
    s1_zero_d = (x_ext == 32'd0);
    if (s1_pass_d) begin
      s1_mag_d = cvt_cell_i_op_x;
    end else if (x_ext[31]) begin
      s1_mag_d = ~x_ext + 32'd1;
    end else begin
      s1_mag_d = x_ext;
    end
  end

  function automatic logic [4:0] clz32(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

  always_comb begin
    s2_lz_d = clz32(s1_mag_q);
  end

  logic [31:0] norm;
  logic [8:0]  exp_raw;
  logic [8:0]  exp_fin;
  logic [22:0] mant_raw;
  logic [22:0] mant_fin;
`ifdef ELM_IN_CVT_ROUND_EN
  logic        rnd_inc;
  logic        rnd_carry;
`endif

  always_comb begin
    norm     = s2_mag_q << s2_lz_q;
    exp_raw  = 9'd158 - {4'd0, s2_lz_q} - {3'd0, fixed_point_quat_accrc};
    mant_raw = norm[30:8];
`ifdef ELM_IN_CVT_ROUND_EN
    // A carry-out leaves the mantissa field at zero, so only the exponent needs bumping.
    rnd_inc               = norm[7] & ((|norm[6:0]) | mant_raw[0]);
    {rnd_carry, mant_fin} = {1'b0, mant_raw} + {23'd0, rnd_inc};
    exp_fin               = exp_raw + {8'd0, rnd_carry};
`else
    mant_fin = mant_raw;
    exp_fin  = exp_raw;
`endif
    if (s2_pass_q) begin
      s3_res_d = s2_mag_q;
    end else if (s2_zero_q) begin
      s3_res_d = 32'd0;
    end else begin
      s3_res_d = {s2_sign_q, exp_fin[7:0], mant_fin};
    end
  end

  logic unused_cfg;
  assign unused_cfg = ^{norm[7:0], exp_fin[8], (SIM_DELAY != 0)};

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_vld_q  <= 1'b0;
      s1_info_q <= '0;
      s1_pass_q <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_mag_q  <= 32'd0;
      s2_vld_q  <= 1'b0;
      s2_info_q <= '0;
      s2_pass_q <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_mag_q  <= 32'd0;
      s2_lz_q   <= 5'd0;
      s3_vld_q  <= 1'b0;
      s3_info_q <= '0;
      s3_res_q  <= 32'd0;
    end else if (aclken) begin
      s1_vld_q  <= cvt_cell_i_vld;
      s1_info_q <= cvt_cell_i_info_along;
      s1_pass_q <= s1_pass_d;
      s1_sign_q <= s1_sign_d;
      s1_zero_q <= s1_zero_d;
      s1_mag_q  <= s1_mag_d;
      s2_vld_q  <= s1_vld_q;
      s2_info_q <= s1_info_q;
      s2_pass_q <= s1_pass_q;
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s1_zero_q;
      s2_mag_q  <= s1_mag_q;
      s2_lz_q   <= s2_lz_d;
      s3_vld_q  <= s2_vld_q;
      s3_info_q <= s2_info_q;
      s3_res_q  <= s3_res_d;
    end
  end

  assign cvt_cell_o_res        = s3_res_q;
  assign cvt_cell_o_info_along = s3_info_q;
  assign cvt_cell_o_vld        = s3_vld_q;

endmodule
